// File: rtl/hiscore_upload_pkg.sv
// Shared types and constants for the hiscore upload server.
// Holds the FSM state encoding, the out-of-range fill byte and the HPS ioctl address width.
package hiscore_upload_pkg;

   localparam int         IOCTL_AW = 25;
   localparam logic [7:0] OOR_BYTE = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PAUSE_WAIT,
      ST_READY,
      ST_FETCH,
      ST_RELEASE
   } state_e;

endpackage

// File: rtl/hiscore_upload_server_if.sv
// HPS ioctl upload port: hps_io drives the master side, the upload server takes the slave side.
// ioctl_wait stalls the HPS; ioctl_din is only consumed while ioctl_wait is low.
interface hiscore_upload_server_if;
   import hiscore_upload_pkg::*;

   logic                ioctl_upload;
   logic [7:0]          ioctl_index;
   logic                ioctl_rd;
   logic [IOCTL_AW-1:0] ioctl_addr;
   logic [7:0]          ioctl_din;
   logic                ioctl_wait;
   logic                ioctl_upload_req;

   modport master (
      output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
      input  ioctl_din, ioctl_wait, ioctl_upload_req
   );

   modport slave (
      input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
      output ioctl_din, ioctl_wait, ioctl_upload_req
   );
endinterface

// File: rtl/upload_sum_acc.sv
// Running 8-bit checksum over bytes fetched in strict sequential order; repeats and skips are not added.
// One-cycle update on add_vld_i; sum_neg_o is the two's complement of the running sum.
module upload_sum_acc #(
   parameter int PTR_W = 13
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             clr_i,
   input  logic             add_vld_i,
   input  logic [PTR_W-1:0] add_off_i,
   input  logic [7:0]       add_dat_i,
   output logic [7:0]       sum_neg_o
);
   logic [7:0]       sum_q;
   logic [PTR_W-1:0] ptr_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sum_q <= 8'd0;
         ptr_q <= '0;
      end else if (clr_i) begin
         sum_q <= 8'd0;
         ptr_q <= '0;
      end else if (add_vld_i && (add_off_i == ptr_q)) begin
         sum_q <= sum_q + add_dat_i;
         ptr_q <= ptr_q + PTR_W'(1);
      end
   end

   assign sum_neg_o = ~sum_q + 8'd1;
endmodule

// File: rtl/hiscore_upload_server.sv
// Serves HPS upload reads of work RAM under a CPU pause; RAM_LAT+2 cycles per byte with the HPS stalled on ioctl_wait.
// HISCORE_UPLOAD_CHECKSUM_EN adds a two's-complement checksum byte at offset LEN.
module hiscore_upload_server
   import hiscore_upload_pkg::*;
#(
   parameter int         ADDR_W  = 12,
   parameter int         BASE    = 0,
   parameter int         LEN     = 64,
   parameter int         RAM_LAT = 1,
   parameter logic [7:0] INDEX   = 8'd4
) (
   input  logic                   clk_sys,
   input  logic                   reset_n,
   hiscore_upload_server_if.slave io,
   input  logic                   save_trigger,
   output logic                   pause_req,
   input  logic                   paused,
   output logic [ADDR_W-1:0]      ram_addr,
   output logic                   ram_rd,
   input  logic [7:0]             ram_data,
   output logic                   busy
);
   localparam logic [IOCTL_AW:0] LEN_C = (IOCTL_AW + 1)'(LEN);
   localparam logic [2:0]        LAT_C = 3'(RAM_LAT);

   state_e            state_q;
   logic              upload_q;
   logic              trig_q;
   logic              rel_q;
   logic [2:0]        lat_cnt_q;
   logic              pause_req_q;
   logic              wait_q;
   logic              upload_req_q;
   logic              ram_rd_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [7:0]        din_q;

   logic       upload_fall;
   logic       trig_rise;
   logic       start;
   logic       rd_in_range;
   logic       active;
   logic [7:0] oor_dat;

   assign upload_fall = ~io.ioctl_upload & upload_q;
   assign trig_rise   = save_trigger & ~trig_q;
   // A start that lands during RELEASE is still high here one cycle later.
   assign start       = io.ioctl_upload & (~upload_q | rel_q) & (io.ioctl_index == INDEX);
   assign rd_in_range = ({1'b0, io.ioctl_addr} < LEN_C);
   assign active      = (state_q == ST_PAUSE_WAIT) || (state_q == ST_READY) || (state_q == ST_FETCH);

`ifdef HISCORE_UPLOAD_CHECKSUM_EN
   logic [ADDR_W:0] fetch_off_q;
   logic [7:0]      sum_neg;
   logic            fetch_done;
   logic            fetch_go;

   assign fetch_go   = (state_q == ST_READY) & paused & ~upload_fall & io.ioctl_rd & rd_in_range;
   assign fetch_done = (state_q == ST_FETCH) & paused & ~upload_fall & (lat_cnt_q == LAT_C);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         fetch_off_q <= '0;
      else if (fetch_go)
         fetch_off_q <= (ADDR_W + 1)'(io.ioctl_addr);
   end

   upload_sum_acc #(.PTR_W(ADDR_W + 1)) u_sum_acc (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .clr_i     ((state_q == ST_IDLE) && start),
      .add_vld_i (fetch_done),
      .add_off_i (fetch_off_q),
      .add_dat_i (ram_data),
      .sum_neg_o (sum_neg)
   );

   assign oor_dat = ({1'b0, io.ioctl_addr} == LEN_C) ? sum_neg : OOR_BYTE;
`else
   assign oor_dat = OOR_BYTE;
`endif

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         upload_q     <= 1'b0;
         trig_q       <= 1'b0;
         rel_q        <= 1'b0;
         lat_cnt_q    <= 3'd0;
         pause_req_q  <= 1'b0;
         wait_q       <= 1'b0;
         upload_req_q <= 1'b0;
         ram_rd_q     <= 1'b0;
         ram_addr_q   <= '0;
         din_q        <= OOR_BYTE;
      end else begin
         upload_q     <= io.ioctl_upload;
         trig_q       <= save_trigger;
         rel_q        <= (state_q == ST_RELEASE);
         upload_req_q <= 1'b0;
         ram_rd_q     <= 1'b0;
         if (active && upload_fall) begin
            state_q     <= ST_RELEASE;
            pause_req_q <= 1'b0;
            wait_q      <= 1'b0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (trig_rise)
                     upload_req_q <= 1'b1;
                  if (start) begin
                     state_q     <= ST_PAUSE_WAIT;
                     pause_req_q <= 1'b1;
                     wait_q      <= 1'b1;
                  end
               end
               ST_PAUSE_WAIT: begin
                  if (paused) begin
                     state_q <= ST_READY;
                     wait_q  <= 1'b0;
                  end
               end
               ST_READY: begin
                  if (!paused) begin
                     state_q <= ST_PAUSE_WAIT;
                     wait_q  <= 1'b1;
                  end else if (io.ioctl_rd) begin
                     if (rd_in_range) begin
                        state_q    <= ST_FETCH;
                        wait_q     <= 1'b1;
                        ram_rd_q   <= 1'b1;
                        ram_addr_q <= ADDR_W'(BASE) + ADDR_W'(io.ioctl_addr);
                        lat_cnt_q  <= 3'd0;
                     end else begin
                        din_q <= oor_dat;
                     end
                  end
               end
               ST_FETCH: begin
                  // Losing the pause abandons the fetch; the late RAM data is never latched.
                  if (!paused) begin
                     state_q <= ST_PAUSE_WAIT;
                     wait_q  <= 1'b1;
                  end else if (lat_cnt_q == LAT_C) begin
                     state_q <= ST_READY;
                     din_q   <= ram_data;
                     wait_q  <= 1'b0;
                  end else begin
                     lat_cnt_q <= lat_cnt_q + 3'd1;
                  end
               end
               ST_RELEASE: state_q <= ST_IDLE;
               default:    state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign io.ioctl_din        = din_q;
   assign io.ioctl_wait       = wait_q;
   assign io.ioctl_upload_req = upload_req_q;
   assign pause_req           = pause_req_q;
   assign ram_addr            = ram_addr_q;
   assign ram_rd              = ram_rd_q;
   assign busy                = (state_q != ST_IDLE);
endmodule

// File: tb/tb_hiscore_upload_server.sv
// Directed bench for hiscore_upload_server: vector table of READY-state reads plus hand sequences for pause/upload corners.
`timescale 1ns/1ps
module tb_hiscore_upload_server;
   localparam int ADDR_W  = 12;
   localparam int BASE    = 'h100;
   localparam int RAM_LAT = 2;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
   localparam int LEN = 3;
`else
   localparam int LEN = 64;
`endif

   logic              clk_sys;
   logic              reset_n;
   logic              save_trigger;
   logic              pause_req;
   logic              paused;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_rd;
   logic [7:0]        ram_data;
   logic              busy;

   hiscore_upload_server_if io ();

   hiscore_upload_server #(
      .ADDR_W  (ADDR_W),
      .BASE    (BASE),
      .LEN     (LEN),
      .RAM_LAT (RAM_LAT),
      .INDEX   (8'd4)
   ) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .io           (io.slave),
      .save_trigger (save_trigger),
      .pause_req    (pause_req),
      .paused       (paused),
      .ram_addr     (ram_addr),
      .ram_rd       (ram_rd),
      .ram_data     (ram_data),
      .busy         (busy)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // RAM model: data is valid only in cycle 1+RAM_LAT after the ram_rd cycle.
   logic [7:0] mem [0:4095];
   logic       pv0, pv1;
   logic [7:0] pd0, pd1;
   always @(posedge clk_sys) begin
      pv0 <= ram_rd;
      pd0 <= mem[ram_addr];
      pv1 <= pv0;
      pd1 <= pd0;
   end
   assign ram_data = pv1 ? pd1 : 8'hEE;

   int   b2b_cnt = 0;
   logic rd_prev = 1'b0;
   always @(negedge clk_sys) begin
      if (ram_rd && rd_prev) b2b_cnt++;
      rd_prev = ram_rd;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " din"},        io.ioctl_din, 8'hFF);
      chk({tag, " wait"},       io.ioctl_wait, 1'b0);
      chk({tag, " upload_req"}, io.ioctl_upload_req, 1'b0);
      chk({tag, " pause_req"},  pause_req, 1'b0);
      chk({tag, " ram_rd"},     ram_rd, 1'b0);
      chk({tag, " ram_addr"},   ram_addr, 12'h000);
      chk({tag, " busy"},       busy, 1'b0);
   endtask

   typedef struct {
      logic [24:0] addr;
      logic [7:0]  mem_byte;
      logic        fetch;
      logic [11:0] exp_ram_addr;
      logic [7:0]  exp_din;
   } vec_t;

   vec_t       vecs[$];
   vec_t       v;
   logic [7:0] last_din;

   initial begin
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
      vecs.push_back(vec_t'{25'd0,    8'h01, 1'b1, 12'h100, 8'h01});
      vecs.push_back(vec_t'{25'd1,    8'h02, 1'b1, 12'h101, 8'h02});
      vecs.push_back(vec_t'{25'd2,    8'h03, 1'b1, 12'h102, 8'h03});
      vecs.push_back(vec_t'{25'd3,    8'h00, 1'b0, 12'h000, 8'hFA});
      vecs.push_back(vec_t'{25'd1,    8'h02, 1'b1, 12'h101, 8'h02});
      vecs.push_back(vec_t'{25'd4,    8'h00, 1'b0, 12'h000, 8'hFF});
      vecs.push_back(vec_t'{25'd3,    8'h00, 1'b0, 12'h000, 8'hFA});
`else
      vecs.push_back(vec_t'{25'd5,    8'h3C, 1'b1, 12'h105, 8'h3C});
      vecs.push_back(vec_t'{25'd0,    8'hA5, 1'b1, 12'h100, 8'hA5});
      vecs.push_back(vec_t'{25'd63,   8'h5A, 1'b1, 12'h13F, 8'h5A});
      vecs.push_back(vec_t'{25'd64,   8'h00, 1'b0, 12'h000, 8'hFF});
      vecs.push_back(vec_t'{25'd7,    8'hC3, 1'b1, 12'h107, 8'hC3});
      vecs.push_back(vec_t'{25'd1000, 8'h00, 1'b0, 12'h000, 8'hFF});
`endif
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

      reset_n          = 1'b0;
      save_trigger     = 1'b0;
      paused           = 1'b0;
      io.ioctl_upload  = 1'b0;
      io.ioctl_index   = 8'd0;
      io.ioctl_rd      = 1'b0;
      io.ioctl_addr    = '0;
      repeat (2) @(posedge clk_sys);
      #1;
      chk_reset_vals("reset");
      reset_n = 1'b1;
      tick();

      // Autosave request in IDLE: exactly one cycle.
      save_trigger = 1'b1;
      tick();
      chk("autosave pulse", io.ioctl_upload_req, 1'b1);
      tick();
      chk("autosave pulse end", io.ioctl_upload_req, 1'b0);
      save_trigger = 1'b0;
      tick();

      // Wrong index is ignored.
      io.ioctl_index  = 8'd0;
      io.ioctl_upload = 1'b1;
      tick();
      chk("wrongidx pause_req", pause_req, 1'b0);
      io.ioctl_rd = 1'b1;
      tick();
      io.ioctl_rd = 1'b0;
      chk("wrongidx ram_rd", ram_rd, 1'b0);
      chk("wrongidx busy", busy, 1'b0);
      io.ioctl_upload = 1'b0;
      tick();

      // Upload start, trigger while busy, early read, pause grant.
      io.ioctl_index  = 8'd4;
      io.ioctl_upload = 1'b1;
      tick();
      chk("start pause_req", pause_req, 1'b1);
      chk("start wait", io.ioctl_wait, 1'b1);
      chk("start busy", busy, 1'b1);
      save_trigger = 1'b1;
      tick();
      chk("busy trig no pulse", io.ioctl_upload_req, 1'b0);
      io.ioctl_rd   = 1'b1;
      io.ioctl_addr = 25'd5;
      tick();
      io.ioctl_rd = 1'b0;
      chk("early rd ram_rd", ram_rd, 1'b0);
      chk("pausewait wait", io.ioctl_wait, 1'b1);
      paused = 1'b1;
      tick();
      chk("ready wait", io.ioctl_wait, 1'b0);
      chk("ready pause_req", pause_req, 1'b1);
      save_trigger = 1'b0;

      last_din = 8'hFF;
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         if (v.fetch) mem[v.exp_ram_addr] = v.mem_byte;
         io.ioctl_addr = v.addr;
         io.ioctl_rd   = 1'b1;
         tick();
         io.ioctl_rd = 1'b0;
         if (v.fetch) begin
            chk($sformatf("v%0d c1 wait", i), io.ioctl_wait, 1'b1);
            chk($sformatf("v%0d c1 ram_rd", i), ram_rd, 1'b1);
            chk($sformatf("v%0d c1 ram_addr", i), ram_addr, v.exp_ram_addr);
            tick();
            chk($sformatf("v%0d c2 wait", i), io.ioctl_wait, 1'b1);
            chk($sformatf("v%0d c2 ram_rd", i), ram_rd, 1'b0);
            tick();
            chk($sformatf("v%0d c3 wait", i), io.ioctl_wait, 1'b1);
            chk($sformatf("v%0d c3 din held", i), io.ioctl_din, last_din);
            tick();
            chk($sformatf("v%0d c4 wait", i), io.ioctl_wait, 1'b0);
            chk($sformatf("v%0d c4 din", i), io.ioctl_din, v.exp_din);
         end else begin
            chk($sformatf("v%0d oor wait", i), io.ioctl_wait, 1'b0);
            chk($sformatf("v%0d oor din", i), io.ioctl_din, v.exp_din);
            chk($sformatf("v%0d oor ram_rd", i), ram_rd, 1'b0);
            tick();
            chk($sformatf("v%0d oor c2 wait", i), io.ioctl_wait, 1'b0);
         end
         last_din = v.exp_din;
      end

      // Pause lost mid-fetch: nothing latched, stall held, back to READY on regrant.
      mem[12'h102] = 8'h77;
      io.ioctl_addr = 25'd2;
      io.ioctl_rd   = 1'b1;
      tick();
      io.ioctl_rd = 1'b0;
      chk("pdrop c1 ram_rd", ram_rd, 1'b1);
      tick();
      paused = 1'b0;
      tick();
      chk("pdrop wait", io.ioctl_wait, 1'b1);
      chk("pdrop pause_req", pause_req, 1'b1);
      chk("pdrop busy", busy, 1'b1);
      tick();
      tick();
      chk("pdrop din held", io.ioctl_din, last_din);
      chk("pdrop wait held", io.ioctl_wait, 1'b1);
      paused = 1'b1;
      tick();
      chk("regrant wait", io.ioctl_wait, 1'b0);
      io.ioctl_addr = 25'd0;
      io.ioctl_rd   = 1'b1;
      tick();
      io.ioctl_rd = 1'b0;
      chk("regrant ram_rd", ram_rd, 1'b1);
      tick();
      tick();
      tick();
      chk("regrant din", io.ioctl_din, mem[12'h100]);
      last_din = mem[12'h100];

      // Upload end mid-fetch, then a new start landing in RELEASE.
      io.ioctl_addr = 25'd1;
      io.ioctl_rd   = 1'b1;
      tick();
      io.ioctl_rd = 1'b0;
      chk("uend c1 ram_rd", ram_rd, 1'b1);
      tick();
      io.ioctl_upload = 1'b0;
      tick();
      chk("uend pause_req", pause_req, 1'b0);
      chk("uend wait", io.ioctl_wait, 1'b0);
      chk("uend busy release", busy, 1'b1);
      io.ioctl_upload = 1'b1;
      tick();
      chk("uend idle", busy, 1'b0);
      chk("uend din held", io.ioctl_din, last_din);
      tick();
      chk("b2b pause_req", pause_req, 1'b1);
      chk("b2b wait", io.ioctl_wait, 1'b1);
      tick();
      chk("b2b ready wait", io.ioctl_wait, 1'b0);

      // Reset asserted mid-fetch: outputs return immediately.
      io.ioctl_addr = 25'd0;
      io.ioctl_rd   = 1'b1;
      tick();
      io.ioctl_rd = 1'b0;
      chk("rst c1 ram_rd", ram_rd, 1'b1);
      #1;
      reset_n = 1'b0;
      #1;
      chk_reset_vals("midreset");
      chk("ram_rd never back-to-back", b2b_cnt, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
